// File: rtl/gb_timer_pkg.sv
// Shared constants for the Game Boy style timer: register map, FSM states
// and the divider tap selection used by the tick generator.
package gb_timer_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    // Register offsets relative to the instance base address.
    localparam logic [1:0] OFS_DIV  = 2'(ADDR_DIV  - ADDR_DIV);
    localparam logic [1:0] OFS_TIMA = 2'(ADDR_TIMA - ADDR_DIV);
    localparam logic [1:0] OFS_TMA  = 2'(ADDR_TMA  - ADDR_DIV);
    localparam logic [1:0] OFS_TAC  = 2'(ADDR_TAC  - ADDR_DIV);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RELOAD = 1'b1
    } timer_state_e;

    function automatic logic tap_bit(input logic [15:0] div, input logic [1:0] sel);
        logic bit_v;
        case (sel)
            2'b00:   bit_v = div[9];
            2'b01:   bit_v = div[3];
            2'b10:   bit_v = div[5];
            2'b11:   bit_v = div[7];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Tick generator: gates the selected divider tap with the enable bit and
// flags every 1->0 transition of the gated tick against its registered value.
module timer_tick_gen
    import gb_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_div,
    input  logic [2:0]  i_tac,
    output logic        o_fall
);

    logic w_tick;
    logic r_tick_prev;

    // Gated tick; a drop caused by a DIV clear or TAC rewrite counts as a fall.
    always_comb begin
        w_tick = i_tac[2] & tap_bit(i_div, i_tac[1:0]);
    end

    // Previous tick value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_prev <= 1'b0;
        end else begin
            r_tick_prev <= w_tick;
        end
    end

    assign o_fall = r_tick_prev & ~w_tick;

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer block: free-running divider, programmable counter
// with delayed TMA reload, sticky interrupt and tri-state register reads.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ADDR_DIV
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MAR,
    input  logic        RE,
    input  logic        WE,
    inout  wire  [7:0]  databus,
    input  logic        int_clear,
    output logic        timer_int
);

    logic [15:0]  r_div;
    logic [7:0]   r_tima;
    logic [7:0]   r_tma;
    logic [2:0]   r_tac;
    logic         r_irq;
    timer_state_e r_state;

    logic [15:0]  w_ofs;
    logic         w_hit;
    logic         w_wr_div;
    logic         w_wr_tima;
    logic         w_wr_tma;
    logic         w_wr_tac;
    logic [7:0]   w_wdata;
    logic         w_fall;
    logic [7:0]   w_tima_nxt;
    timer_state_e w_state_nxt;
    logic         w_irq_set;
    logic [7:0]   w_rdata;
    logic         w_drive;

    // Address decode; subtracting the base keeps the window check a single compare.
    always_comb begin
        w_ofs     = MAR - BASE_ADDR;
        w_hit     = (w_ofs < 16'd4);
        w_wr_div  = WE & w_hit & (w_ofs[1:0] == OFS_DIV);
        w_wr_tima = WE & w_hit & (w_ofs[1:0] == OFS_TIMA);
        w_wr_tma  = WE & w_hit & (w_ofs[1:0] == OFS_TMA);
        w_wr_tac  = WE & w_hit & (w_ofs[1:0] == OFS_TAC);
        w_wdata   = databus;
    end

    // Free-running divider; any DIV write clears all 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 16'd0;
        end else if (w_wr_div) begin
            r_div <= 16'd0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // Modulo and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tma <= 8'd0;
            r_tac <= 3'd0;
        end else begin
            if (w_wr_tma) begin
                r_tma <= w_wdata;
            end
            if (w_wr_tac) begin
                r_tac <= w_wdata[2:0];
            end
        end
    end

    timer_tick_gen u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_div  (r_div),
        .i_tac  (r_tac),
        .o_fall (w_fall)
    );

    // Counter next-state: overflow parks TIMA at 00 for one RELOAD cycle.
    always_comb begin
        w_tima_nxt  = r_tima;
        w_state_nxt = ST_IDLE;
        w_irq_set   = 1'b0;
        case (r_state)
            ST_RELOAD: begin
                if (w_wr_tima) begin
                    w_tima_nxt = w_wdata;
                end else if (w_wr_tma) begin
                    w_tima_nxt = w_wdata;
                    w_irq_set  = 1'b1;
                end else begin
                    w_tima_nxt = r_tma;
                    w_irq_set  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_wr_tima) begin
                    w_tima_nxt = w_wdata;
                end else if (w_fall) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_nxt  = 8'h00;
                        w_state_nxt = ST_RELOAD;
                    end else begin
                        w_tima_nxt = r_tima + 8'd1;
                    end
                end else begin
                    w_tima_nxt = r_tima;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tima  <= 8'd0;
            r_state <= ST_IDLE;
        end else begin
            r_tima  <= w_tima_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Sticky interrupt flag; a same-cycle set beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (int_clear) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq;
        end
    end

    // Read mux; unused TAC bits read back as ones.
    always_comb begin
        case (w_ofs[1:0])
            OFS_DIV:  w_rdata = r_div[15:8];
            OFS_TIMA: w_rdata = r_tima;
            OFS_TMA:  w_rdata = r_tma;
            OFS_TAC:  w_rdata = {5'b11111, r_tac};
            default:  w_rdata = 8'h00;
        endcase
        w_drive = RE & ~WE & w_hit & ~rst;
    end

    assign databus   = w_drive ? w_rdata : 8'bzzzz_zzzz;
    assign timer_int = r_irq;

endmodule

// File: doc/gb_timer.md
GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF04, address of DIV; TIMA/TMA/TAC at BASE_ADDR+1/+2/+3.
REQ-002 SHALL have port clk  input  1  system clock, one tick per CPU T-cycle.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port MAR  input  16  memory address from CPU datapath.
REQ-005 SHALL have port RE  input  1  CPU read strobe.
REQ-006 SHALL have port WE  input  1  CPU write strobe.
REQ-007 SHALL have port databus  inout  8  shared tri-state data bus.
REQ-008 SHALL have port int_clear  input  1  interrupt acknowledge from CPU.
REQ-009 SHALL have port timer_int  output  1  timer interrupt request to CPU.

Function
REQ-010 SHALL contain a 16-bit free-running divider incremented every clk, wrapping FFFF->0000.
REQ-011 SHALL return divider[15:8] on DIV reads.
REQ-012 SHALL clear the whole 16-bit divider on any DIV write; write data ignored.
REQ-013 SHALL hold 8-bit TIMA, TMA registers and 3-bit TAC (bit2 enable, bits1:0 select).
REQ-014 SHALL select tap bit: TAC[1:0]=00 -> divider[9], 01 -> divider[3], 10 -> divider[5], 11 -> divider[7].
REQ-015 SHALL form tick = TAC[2] AND selected tap; TIMA increments by 1 on each 1->0 transition of tick (registered previous value).
REQ-016 SHALL therefore increment TIMA on falling edges caused by DIV writes or TAC writes (enable clear or select change), matching hardware glitch behaviour.
REQ-017 SHALL, on TIMA increment from FF, set TIMA to 00 and enter a one-cycle RELOAD state.
REQ-018 SHALL, in the RELOAD cycle, load TIMA <= TMA and set the interrupt flag; state returns to IDLE.
REQ-019 SHALL, if the CPU writes TIMA during the RELOAD cycle, cancel reload and interrupt; written value wins.
REQ-020 SHALL, if the CPU writes TMA during the RELOAD cycle, load the new TMA value into TIMA.
REQ-021 SHALL give a CPU TIMA write priority over a same-cycle increment (increment lost).
REQ-022 SHALL drive timer_int from a sticky flag: set per REQ-018, cleared when int_clear=1; set wins if both same cycle.
REQ-023 SHALL drive databus combinationally only when RE=1, WE=0 and MAR in BASE_ADDR..BASE_ADDR+3; else 8'bz.
REQ-024 SHALL read TAC as {5'b11111, TAC}.
REQ-025 SHALL capture writes on posedge clk when WE=1 and MAR matches; other addresses ignored.
REQ-026 SHALL ignore RE and WE asserted together for reads (no bus drive).

Reset
REQ-027 SHALL on rst clear divider, TIMA, TMA, TAC, previous tick, interrupt flag to 0 and state to IDLE, immediately.
REQ-028 SHALL abort a pending RELOAD on rst; no interrupt raised.
REQ-029 SHALL release databus (8'bz) while rst=1.

Structure
REQ-030 SHALL place register addresses (DIV/TIMA/TMA/TAC) and the state enum {IDLE, RELOAD} in the shared constants package.
REQ-031 SHALL implement tap selection plus falling-edge detection as one sub-module, timer_tick_gen; all else in gb_timer.

Verification
REQ-032 SHALL test: TAC=3'b101, TIMA=0 -> TIMA=1 after 16 clks, =4 after 64.
REQ-033 SHALL test: TMA=8'hAB, TAC=3'b101, TIMA=8'hFF -> at overflow TIMA reads 00 one cycle, then AB, timer_int=1 until int_clear pulse.
REQ-034 SHALL test: TIMA write 8'h10 in RELOAD cycle -> TIMA=10, timer_int stays 0.
REQ-035 SHALL test: TAC=3'b100, divider[9]=1, write DIV -> divider=0, TIMA increments once.
REQ-036 SHALL test: 256 clks after reset DIV reads 01; read FF07 with TAC=3'b110 returns FE; read FF08 leaves bus z.
REQ-037 SHALL test: rst asserted mid-RELOAD -> all registers 0, timer_int 0 same cycle.
